// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 constants, pattern encodings, total helper
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_ACT = 1'b0;

  typedef enum logic [1:0] {
    RAMP_H  = 2'd0,
    RAMP_V  = 2'd1,
    CHECKER = 2'd2,
    FLAT    = 2'd3
  } pattern_e;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - video timing stream bundle: source drives sync/blank/luma/coords
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             blank;
  logic [7:0]       y0;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frame_start;
  logic [1:0]       pattern_sel;

  modport master (
    output hsync, vsync, blank, y0, x, y, frame_start,
    input  pattern_sel
  );

  modport slave (
    input  hsync, vsync, blank, y0, x, y, frame_start,
    output pattern_sel
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one timing axis: position counter with active/sync decode and wrap
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit SYNC_ACT = DEF_SYNC_ACT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  assign wrap   = step && (count == LAST);
  assign active = (count < ACT_END);
  assign sync   = ((count >= SYNC_BEG) && (count < SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing and test-pattern source, one pixel per clock
// Outputs register the decode of the current counter position, so all outputs stay aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_ACT = DEF_SYNC_ACT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pattern_sel,
  output logic             o_HSYNC,
  output logic             o_VSYNC,
  output logic             o_BLANK,
  output logic [7:0]       o_Y0,
  output logic [CNT_W-1:0] o_X,
  output logic [CNT_W-1:0] o_Y,
  output logic             o_frame_start
);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             h_active;
  logic             v_active;
  logic             h_sync;
  logic             v_sync;
  logic             h_wrap;
  logic             v_wrap;
  logic             at_origin;
  pattern_e         pat_q;
  logic [7:0]       pix;
  logic             blank_d;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_ACT(SYNC_ACT)
  ) u_h_cnt (
    .clk(clk), .rst_n(rst_n), .step(1'b1),
    .count(h), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_ACT(SYNC_ACT)
  ) u_v_cnt (
    .clk(clk), .rst_n(rst_n), .step(h_wrap),
    .count(v), .active(v_active), .sync(v_sync), .wrap(v_wrap)
  );

  assign blank_d = h_active && v_active;

  always_comb begin
    pix = 8'h00;
    case (pat_q)
      RAMP_H:  pix = h[7:0];
      RAMP_V:  pix = v[7:0];
      CHECKER: pix = (h[3] ^ v[3]) ? 8'hFF : 8'h00;
      FLAT:    pix = 8'h80;
      default: pix = 8'h00;
    endcase
  end

  // The new selection is loaded as the counters leave the last position, so the
  // frame that the following strobe opens uses it from (0,0); the frame after
  // reset always runs the reset pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_origin     <= 1'b1;
      pat_q         <= RAMP_H;
      o_HSYNC       <= ~SYNC_ACT;
      o_VSYNC       <= ~SYNC_ACT;
      o_BLANK       <= 1'b0;
      o_Y0          <= 8'h00;
      o_X           <= '0;
      o_Y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      at_origin     <= v_wrap;
      if (v_wrap) begin
        pat_q <= pattern_e'(pattern_sel);
      end
      o_HSYNC       <= h_sync;
      o_VSYNC       <= v_sync;
      o_BLANK       <= blank_d;
      o_Y0          <= blank_d ? pix : 8'h00;
      o_X           <= h;
      o_Y           <= v;
      o_frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen in default, small and medium configs
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [7:0]  y0;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
  } vout_t;

  localparam vout_t RST = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, y0: 8'h00, x: 11'd0, y: 11'd0, fs: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn [3] = '{1'b0, 1'b0, 1'b0};
  int n_checks = 0;
  int n_errors = 0;

  vga_timing_if vif_d();
  vga_timing_if vif_s();
  vga_timing_if vif_m();

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rstn[0]), .pattern_sel(vif_d.pattern_sel),
    .o_HSYNC(vif_d.hsync), .o_VSYNC(vif_d.vsync), .o_BLANK(vif_d.blank), .o_Y0(vif_d.y0),
    .o_X(vif_d.x), .o_Y(vif_d.y), .o_frame_start(vif_d.frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACT(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rstn[1]), .pattern_sel(vif_s.pattern_sel),
    .o_HSYNC(vif_s.hsync), .o_VSYNC(vif_s.vsync), .o_BLANK(vif_s.blank), .o_Y0(vif_s.y0),
    .o_X(vif_s.x), .o_Y(vif_s.y), .o_frame_start(vif_s.frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACT(1'b0)
  ) dut_m (
    .clk(clk), .rst_n(rstn[2]), .pattern_sel(vif_m.pattern_sel),
    .o_HSYNC(vif_m.hsync), .o_VSYNC(vif_m.vsync), .o_BLANK(vif_m.blank), .o_Y0(vif_m.y0),
    .o_X(vif_m.x), .o_Y(vif_m.y), .o_frame_start(vif_m.frame_start)
  );

  vout_t      obs  [3];
  logic [1:0] selv [3];
  assign obs[0] = {vif_d.hsync, vif_d.vsync, vif_d.blank, vif_d.y0, vif_d.x, vif_d.y, vif_d.frame_start};
  assign obs[1] = {vif_s.hsync, vif_s.vsync, vif_s.blank, vif_s.y0, vif_s.x, vif_s.y, vif_s.frame_start};
  assign obs[2] = {vif_m.hsync, vif_m.vsync, vif_m.blank, vif_m.y0, vif_m.x, vif_m.y, vif_m.frame_start};
  assign selv[0] = vif_d.pattern_sel;
  assign selv[1] = vif_s.pattern_sel;
  assign selv[2] = vif_m.pattern_sel;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input vout_t got, input vout_t exp);
    chk_eq({tag, ".hsync"}, int'(got.hs), int'(exp.hs));
    chk_eq({tag, ".vsync"}, int'(got.vs), int'(exp.vs));
    chk_eq({tag, ".blank"}, int'(got.bl), int'(exp.bl));
    chk_eq({tag, ".y0"},    int'(got.y0), int'(exp.y0));
    chk_eq({tag, ".x"},     int'(got.x),  int'(exp.x));
    chk_eq({tag, ".y"},     int'(got.y),  int'(exp.y));
    chk_eq({tag, ".fs"},    int'(got.fs), int'(exp.fs));
  endtask

  function automatic void get_cfg(input int id, output int ha, output int hf, output int hw, output int hb,
                                  output int va, output int vf, output int vw, output int vb);
    if (id == 0) begin
      ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
    end else if (id == 1) begin
      ha = 8; hf = 2; hw = 2; hb = 2; va = 4; vf = 1; vw = 1; vb = 1;
    end else begin
      ha = 32; hf = 2; hw = 2; hb = 2; va = 16; vf = 1; vw = 1; vb = 1;
    end
  endfunction

  function automatic int frame_len(input int id);
    int ha, hf, hw, hb, va, vf, vw, vb;
    get_cfg(id, ha, hf, hw, hb, va, vf, vw, vb);
    return (ha + hf + hw + hb) * (va + vf + vw + vb);
  endfunction

  // Expected output for the pos-th pixel clock since release, derived from a flat clock index.
  function automatic vout_t model(input int id, input int pos, input logic [1:0] pat);
    int ha, hf, hw, hb, va, vf, vw, vb, ht, p, h, v, lum;
    vout_t e;
    get_cfg(id, ha, hf, hw, hb, va, vf, vw, vb);
    ht = ha + hf + hw + hb;
    p  = pos % frame_len(id);
    h  = p % ht;
    v  = p / ht;
    e.hs = !((h >= ha + hf) && (h < ha + hf + hw));
    e.vs = !((v >= va + vf) && (v < va + vf + vw));
    e.bl = (h < ha) && (v < va);
    case (pat)
      2'd0:    lum = h % 256;
      2'd1:    lum = v % 256;
      2'd2:    lum = (((h / 8) % 2) != ((v / 8) % 2)) ? 255 : 0;
      default: lum = 128;
    endcase
    e.y0 = e.bl ? 8'(lum) : 8'h00;
    e.x  = 11'(h);
    e.y  = 11'(v);
    e.fs = (p == 0);
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : sb
    vout_t      q[$];
    int         cnt = 0;
    logic [1:0] pat = 2'd0;

    always @(posedge clk) begin
      if (!rstn[g]) begin
        cnt = 0;
        pat = 2'd0;
      end else begin
        q.push_back(model(g, cnt, pat));
        if ((cnt % frame_len(g)) == frame_len(g) - 1) pat = selv[g];
        cnt++;
      end
    end

    always @(negedge clk) begin
      if (!rstn[g]) q.delete();
      else if (q.size() > 0) chk_out($sformatf("sb%0d", g), obs[g], q.pop_front());
    end
  end

  task automatic wait_at(input int id, input int x, input int y, input int bound);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = (int'(obs[id].x) == x) && (int'(obs[id].y) == y);
    end
    chk_eq($sformatf("reach%0d(%0d,%0d)", id, x, y), int'(hit), 1);
  endtask

  task automatic wait_fs(input int id, input int bound, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = obs[id].fs;
    end
    chk_eq($sformatf("fs_seen%0d", id), int'(hit), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vif_d.pattern_sel = 2'd2;
    vif_s.pattern_sel = 2'd0;
    vif_m.pattern_sel = 2'd2;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_out($sformatf("reset%0d", i), obs[i], RST);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    rstn[2] = 1'b1;

    fork
      begin : default_cfg
        int lowcnt, first_low, blcnt, last_bl;
        lowcnt = 0; first_low = -1; blcnt = 0; last_bl = -1;
        @(negedge clk);
        chk_eq("d first fs", int'(obs[0].fs), 1);
        chk_eq("d first blank", int'(obs[0].bl), 1);
        chk_eq("d first hsync", int'(obs[0].hs), 1);
        chk_eq("d first vsync", int'(obs[0].vs), 1);
        chk_eq("d first y", int'(obs[0].y), 0);
        for (int i = 0; i < 800; i++) begin
          if (i > 0) @(negedge clk);
          chk_eq("d line x", int'(obs[0].x), i);
          if (!obs[0].hs) begin
            if (first_low < 0) first_low = int'(obs[0].x);
            lowcnt++;
          end
          if (obs[0].bl) begin
            blcnt++;
            last_bl = int'(obs[0].x);
          end
          if (i == 5)   chk_eq("d y0@(5,0)", int'(obs[0].y0), 5);
          if (i == 300) chk_eq("d y0@(300,0)", int'(obs[0].y0), 44);
          if (i == 700) chk_eq("d y0@(700,0)", int'(obs[0].y0), 0);
        end
        chk_eq("d hsync width", lowcnt, 96);
        chk_eq("d hsync start", first_low, 656);
        chk_eq("d blank count", blcnt, 640);
        chk_eq("d blank last x", last_bl, 639);
        @(negedge clk);
        chk_eq("d line1 x", int'(obs[0].x), 0);
        chk_eq("d line1 y", int'(obs[0].y), 1);
        wait_at(0, 8, 8, 8000);
        chk_eq("d first frame ramp@(8,8)", int'(obs[0].y0), 8);
      end

      begin : small_cfg
        int n;
        wait_at(1, 5, 0, 200);
        #1 rstn[1] = 1'b0;
        #1 chk_out("s async", obs[1], RST);
        @(negedge clk);
        chk_out("s held", obs[1], RST);
        #1 rstn[1] = 1'b1;
        @(negedge clk);
        chk_eq("s restart x", int'(obs[1].x), 0);
        chk_eq("s restart y", int'(obs[1].y), 0);
        chk_eq("s restart fs", int'(obs[1].fs), 1);
        chk_eq("s restart blank", int'(obs[1].bl), 1);
        wait_at(1, 0, 5, 200);
        chk_eq("s vsync@(0,5)", int'(obs[1].vs), 0);
        chk_eq("s blank@(0,5)", int'(obs[1].bl), 0);
        wait_at(1, 13, 4, 200);
        chk_eq("s vsync@(13,4)", int'(obs[1].vs), 1);
        wait_at(1, 0, 6, 200);
        chk_eq("s vsync@(0,6)", int'(obs[1].vs), 1);
        wait_fs(1, 200, n);
        chk_eq("s to wrap", n, 14);
        wait_fs(1, 200, n);
        chk_eq("s frame period", n, 98);
        wait_at(1, 0, 2, 200);
        vif_s.pattern_sel = 2'd3;
        wait_at(1, 3, 2, 200);
        chk_eq("s ramp after sel change", int'(obs[1].y0), 3);
        wait_fs(1, 200, n);
        chk_eq("s to next frame", n, 67);
        wait_at(1, 3, 1, 200);
        chk_eq("s flat next frame", int'(obs[1].y0), 128);
      end

      begin : medium_cfg
        int n;
        wait_at(2, 8, 0, 1000);
        chk_eq("m first frame ramp", int'(obs[2].y0), 8);
        wait_at(2, 37, 16, 1000);
        chk_eq("m vsync@(37,16)", int'(obs[2].vs), 1);
        chk_eq("m blank@(37,16)", int'(obs[2].bl), 0);
        wait_at(2, 0, 17, 1000);
        chk_eq("m vsync@(0,17)", int'(obs[2].vs), 0);
        wait_at(2, 37, 17, 1000);
        chk_eq("m vsync@(37,17)", int'(obs[2].vs), 0);
        wait_at(2, 0, 18, 1000);
        chk_eq("m vsync@(0,18)", int'(obs[2].vs), 1);
        wait_fs(2, 1000, n);
        chk_eq("m to wrap", n, 38);
        wait_at(2, 8, 0, 1000);
        chk_eq("m checker@(8,0)", int'(obs[2].y0), 255);
        wait_at(2, 34, 0, 1000);
        chk_eq("m blank y0@(34,0)", int'(obs[2].y0), 0);
        wait_at(2, 0, 8, 1000);
        chk_eq("m checker@(0,8)", int'(obs[2].y0), 255);
        wait_at(2, 8, 8, 1000);
        chk_eq("m checker@(8,8)", int'(obs[2].y0), 0);
        wait_at(2, 0, 10, 1000);
        vif_m.pattern_sel = 2'd3;
        wait_at(2, 31, 15, 1000);
        chk_eq("m checker holds@(31,15)", int'(obs[2].y0), 0);
        wait_fs(2, 1000, n);
        chk_eq("m to frame2", n, 121);
        wait_at(2, 1, 0, 1000);
        chk_eq("m flat@(1,0)", int'(obs[2].y0), 128);
        wait_at(2, 5, 3, 1000);
        chk_eq("m flat@(5,3)", int'(obs[2].y0), 128);
        wait_fs(2, 1000, n);
        chk_eq("m to frame3", n, 603);
        wait_fs(2, 1000, n);
        chk_eq("m frame period", n, 722);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
